deco_count_ctrl: RTL and testbench
==================================

Name: deco_count_ctrl

Overview:
- Sequencing controller for the two-digit seven-segment decoder.
- Generates the N-bit `number` the decoder consumes: a prescaled up/down counter with start/pause/clear/load control and a terminal-count state machine.
- Sits between the board push-buttons/switches (already debounced and pulsed upstream) and the decoder input.

Parameters:
- N, 6, counter width; matches the decoder input width.
- DIV, 50000000, clock cycles per count step (prescaler period, ≥2).
- MAXV, 63, highest count value (≤ 2^N−1); the count range is 0..MAXV.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse: start or resume counting.
- stop  in  1  single-cycle pulse: pause counting.
- clear  in  1  single-cycle pulse: return to IDLE, count to 0.
- load  in  1  single-cycle pulse: load `load_val`.
- load_val  in  N  preset value.
- up  in  1  direction, 1 = increment, 0 = decrement; sampled at each step.
- wrap_en  in  1  1 = wrap at range ends, 0 = stop in DONE; sampled at each step.
- number  out  N  registered count, drives the decoder.
- state_o  out  2  IDLE=0, RUN=1, PAUSE=2, DONE=3.
- tick_o  out  1  one-cycle pulse on each count step.
- done  out  1  one-cycle pulse on entry to DONE.

Behaviour:
- One clock domain; all outputs registered.
- Async reset (rst_n=0) immediately forces: number=0, state=IDLE, prescaler=0, tick_o=0, done=0. The first active edge after release is a normal cycle.
- Prescaler `pre` (0..DIV−1):
  - Counts only in RUN.
  - When pre==DIV−1: tick_o=1 next cycle, pre→0, and the count steps in that same edge.
  - PAUSE holds pre.
  - IDLE and DONE force pre=0.
- First step occurs DIV cycles after the start pulse from IDLE/DONE. After resume from PAUSE, it occurs DIV−pre_held cycles later.
- Control priority per cycle: clear > load > stop > start.
- clear (any state): number=0, pre=0, state→IDLE. Any simultaneous tick is discarded.
- load:
  - Accepted in IDLE, PAUSE, DONE; ignored in RUN.
  - number = min(load_val, MAXV).
  - IDLE/PAUSE keep their state; DONE→IDLE. pre unchanged in PAUSE.
- State transitions:
  - IDLE: start → RUN.
  - RUN: stop → PAUSE; start ignored; terminal step with wrap_en=0 → DONE.
  - PAUSE: start → RUN (resume); stop ignored.
  - DONE: start → RUN, with number reloaded to 0 if up=1 or MAXV if up=0; stop ignored.
- Same-cycle start+stop: stop wins (RUN→PAUSE; PAUSE stays PAUSE; IDLE/DONE go to RUN, since stop has no effect there).
- Step rule (RUN, on prescaler terminal):
  - up=1, number<MAXV: number+1.
  - up=1, number==MAXV: wrap_en ? 0 : hold MAXV and →DONE.
  - up=0, number>0: number−1.
  - up=0, number==0: wrap_en ? MAXV : hold 0 and →DONE.
  - No value outside 0..MAXV is ever produced. A number > MAXV is impossible, because load saturates.
- done=1 for exactly the cycle after the DONE transition edge. tick_o also pulses on that terminal step.
- A stop arriving in the same cycle as the prescaler terminal takes priority: no step, pre is held at DIV−1, and the step occurs on the first cycle after resume.

Test Plan:
- Reset/count: DIV=4, MAXV=9, up=1, wrap_en=0, pulse start → number 1,2,…,9 at cycles 4,8,…,36 after start; state DONE and done=1 once after reaching 9; number holds 9.
- Wrap down: load_val=2 in IDLE, up=0, wrap_en=1, start → sequence 1,0,9,8; state stays RUN; done never asserts.
- Pause/resume: start, stop at pre==1 with number=3 → number holds 3 for 20 cycles; start → next step to 4 after exactly 3 cycles.
- Priority: assert clear+load+start together while RUN at number=5 → number=0, state IDLE, no tick. Then load_val=63 with MAXV=9 → number=9 (saturated).
- Collisions: stop on the prescaler-terminal cycle → no step, state PAUSE. start+stop together in RUN → PAUSE. load while RUN → ignored.
- Async reset mid-RUN at number=7, asserted between clock edges → outputs go to 0/IDLE before the next edge; counting resumes only after a new start.

Source files
------------

// File: rtl/deco_count_ctrl.sv
// Sequencing controller for the two-digit seven-segment decoder: a prescaled
// up/down counter with start/pause/clear/load control and terminal-count FSM.
module deco_count_ctrl #(
  parameter int N    = 6,
  parameter int DIV  = 50000000,
  parameter int MAXV = 63
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         stop,
  input  logic         clear,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         up,
  input  logic         wrap_en,
  output logic [N-1:0] number,
  output logic [1:0]   state_o,
  output logic         tick_o,
  output logic         done
);

  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] PRE_ONE  = PW'(1);
  localparam logic [N-1:0]  MAX_NUM  = N'(MAXV);
  localparam logic [N-1:0]  NUM_ONE  = N'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] pre, pre_nxt;
  logic [N-1:0]  number_nxt;
  logic          tick_nxt, done_nxt;
  logic [N-1:0]  load_sat;
  logic          pre_term;

  assign load_sat = (load_val > MAX_NUM) ? MAX_NUM : load_val;
  assign pre_term = (pre == PRE_LAST);
  assign state_o  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      pre    <= '0;
      number <= '0;
      tick_o <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      pre    <= pre_nxt;
      number <= number_nxt;
      tick_o <= tick_nxt;
      done   <= done_nxt;
    end
  end

  // Highest-priority control wins; a stop on the prescaler terminal cycle
  // freezes pre at its last value so the step fires right after resume.
  always_comb begin
    state_nxt  = state;
    pre_nxt    = pre;
    number_nxt = number;
    tick_nxt   = 1'b0;
    done_nxt   = 1'b0;

    if (clear) begin
      state_nxt  = IDLE;
      pre_nxt    = '0;
      number_nxt = '0;
    end else if (load && (state != RUN)) begin
      number_nxt = load_sat;
      if (state == DONE) state_nxt = IDLE;
      if (state != PAUSE) pre_nxt = '0;
    end else if (stop && ((state == RUN) || (state == PAUSE))) begin
      state_nxt = PAUSE;
    end else if (start && (state != RUN)) begin
      state_nxt = RUN;
      if (state == DONE) number_nxt = up ? '0 : MAX_NUM;
      if (state != PAUSE) pre_nxt = '0;
    end else if (state == RUN) begin
      if (pre_term) begin
        pre_nxt  = '0;
        tick_nxt = 1'b1;
        if (up) begin
          if (number < MAX_NUM) begin
            number_nxt = number + NUM_ONE;
          end else if (wrap_en) begin
            number_nxt = '0;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end else begin
          if (number != '0) begin
            number_nxt = number - NUM_ONE;
          end else if (wrap_en) begin
            number_nxt = MAX_NUM;
          end else begin
            state_nxt = DONE;
            done_nxt  = 1'b1;
          end
        end
      end else begin
        pre_nxt = pre + PRE_ONE;
      end
    end else if (state != PAUSE) begin
      pre_nxt = '0;
    end
  end

endmodule

// File: tb/tb_deco_count_ctrl.sv
// Self-checking bench for deco_count_ctrl: directed vector table, multi-cycle
// corner sequences, then random traffic against a rule-level reference model.
module tb_deco_count_ctrl;

  localparam int N    = 6;
  localparam int DIV  = 4;
  localparam int MAXV = 9;

  localparam int S_IDLE  = 0;
  localparam int S_RUN   = 1;
  localparam int S_PAUSE = 2;
  localparam int S_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start, stop, clear, load, up, wrap_en;
  logic [N-1:0] load_val;
  logic [N-1:0] number;
  logic [1:0]   state_o;
  logic         tick_o, done;

  int vectors = 0;
  int miscompares = 0;

  int m_num, m_st, m_pre;
  bit m_tick, m_done;

  typedef struct {
    logic       st, sp, cl, ld;
    logic [5:0] lv;
    logic       u, w;
    int         num, stt;
    logic       tk, dn;
  } vec_t;

  vec_t vecs[21];
  int   seq_b[5];

  deco_count_ctrl #(.N(N), .DIV(DIV), .MAXV(MAXV)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .stop     (stop),
    .clear    (clear),
    .load     (load),
    .load_val (load_val),
    .up       (up),
    .wrap_en  (wrap_en),
    .number   (number),
    .state_o  (state_o),
    .tick_o   (tick_o),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_num = 0; m_st = S_IDLE; m_pre = 0; m_tick = 0; m_done = 0;
  endtask

  // Reference: applies the control rules directly; a step is "count +/- 1",
  // and any result leaving 0..MAXV either wraps or ends the run.
  task automatic model_edge(input bit st, input bit sp, input bit cl, input bit ld,
                            input int lv, input bit u, input bit w);
    int nxt;
    m_tick = 0;
    m_done = 0;
    if (cl) begin
      m_num = 0; m_pre = 0; m_st = S_IDLE;
    end else if (ld && m_st != S_RUN) begin
      m_num = (lv > MAXV) ? MAXV : lv;
      if (m_st != S_PAUSE) m_pre = 0;
      if (m_st == S_DONE) m_st = S_IDLE;
    end else if (sp && (m_st == S_RUN || m_st == S_PAUSE)) begin
      m_st = S_PAUSE;
    end else if (st && m_st != S_RUN) begin
      if (m_st == S_DONE) m_num = u ? 0 : MAXV;
      if (m_st != S_PAUSE) m_pre = 0;
      m_st = S_RUN;
    end else if (m_st == S_RUN) begin
      if (m_pre == DIV - 1) begin
        m_pre  = 0;
        m_tick = 1;
        nxt = u ? m_num + 1 : m_num - 1;
        if (nxt >= 0 && nxt <= MAXV) m_num = nxt;
        else if (w) m_num = (nxt < 0) ? MAXV : 0;
        else begin m_st = S_DONE; m_done = 1; end
      end else begin
        m_pre++;
      end
    end
  endtask

  task automatic apply_stimulus(input bit st, input bit sp, input bit cl, input bit ld,
                                input int lv, input bit u, input bit w);
    start = st; stop = sp; clear = cl; load = ld;
    load_val = N'(lv); up = u; wrap_en = w;
    @(posedge clk);
    model_edge(st, sp, cl, ld, lv, u, w);
    #1;
    start = 0; stop = 0; clear = 0; load = 0;
  endtask

  task automatic idle_cycle(input bit u, input bit w);
    apply_stimulus(0, 0, 0, 0, 0, u, w);
  endtask

  task automatic check_model(input string tag);
    check_output({tag, "_number"}, number, m_num);
    check_output({tag, "_state"}, state_o, m_st);
    check_output({tag, "_tick"}, tick_o, m_tick);
    check_output({tag, "_done"}, done, m_done);
  endtask

  initial begin
    vecs[0]  = '{0,0,0,1,63,1,0, 9,S_IDLE, 0,0};
    vecs[1]  = '{0,0,0,1, 2,1,0, 2,S_IDLE, 0,0};
    vecs[2]  = '{0,0,1,0, 0,1,0, 0,S_IDLE, 0,0};
    vecs[3]  = '{1,0,0,1, 7,1,0, 7,S_IDLE, 0,0};
    vecs[4]  = '{0,1,0,0, 0,1,0, 7,S_IDLE, 0,0};
    vecs[5]  = '{1,1,0,0, 0,1,0, 7,S_RUN,  0,0};
    vecs[6]  = '{0,0,0,1, 3,1,0, 7,S_RUN,  0,0};
    vecs[7]  = '{1,0,0,0, 0,1,0, 7,S_RUN,  0,0};
    vecs[8]  = '{0,0,0,0, 0,1,0, 7,S_RUN,  0,0};
    vecs[9]  = '{0,1,0,0, 0,1,0, 7,S_PAUSE,0,0};
    vecs[10] = '{1,1,0,0, 0,1,0, 7,S_PAUSE,0,0};
    vecs[11] = '{1,0,0,0, 0,1,0, 7,S_RUN,  0,0};
    vecs[12] = '{0,0,0,0, 0,1,0, 8,S_RUN,  1,0};
    vecs[13] = '{1,0,1,1, 0,1,0, 0,S_IDLE, 0,0};
    vecs[14] = '{0,0,0,1, 9,1,0, 9,S_IDLE, 0,0};
    vecs[15] = '{1,0,0,0, 0,1,0, 9,S_RUN,  0,0};
    vecs[16] = '{0,0,0,0, 0,1,0, 9,S_RUN,  0,0};
    vecs[17] = '{0,0,0,0, 0,1,0, 9,S_RUN,  0,0};
    vecs[18] = '{0,0,0,0, 0,1,0, 9,S_RUN,  0,0};
    vecs[19] = '{0,0,0,0, 0,1,0, 9,S_DONE, 1,1};
    vecs[20] = '{0,0,0,1, 4,1,0, 4,S_IDLE, 0,0};
    seq_b = '{2, 1, 0, 9, 8};

    rst_n = 0; start = 0; stop = 0; clear = 0; load = 0;
    load_val = '0; up = 1; wrap_en = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset_number", number, 0);
    check_output("reset_state", state_o, S_IDLE);
    check_output("reset_tick", tick_o, 0);
    check_output("reset_done", done, 0);
    #2 rst_n = 1;

    for (int i = 0; i < 21; i++) begin
      apply_stimulus(vecs[i].st, vecs[i].sp, vecs[i].cl, vecs[i].ld,
                     int'(vecs[i].lv), vecs[i].u, vecs[i].w);
      check_output($sformatf("vec%0d_number", i), number, vecs[i].num);
      check_output($sformatf("vec%0d_state", i), state_o, vecs[i].stt);
      check_output($sformatf("vec%0d_tick", i), tick_o, vecs[i].tk);
      check_output($sformatf("vec%0d_done", i), done, vecs[i].dn);
    end

    // Count up to MAXV, then the terminal step without wrap ends in DONE.
    apply_stimulus(0, 0, 1, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 44; k++) begin
      idle_cycle(1, 0);
      check_output($sformatf("cnt%0d_number", k), number, (k / 4 > MAXV) ? MAXV : k / 4);
      check_output($sformatf("cnt%0d_tick", k), tick_o, (k % 4 == 0) && (k <= 40));
      check_output($sformatf("cnt%0d_state", k), state_o, (k >= 40) ? S_DONE : S_RUN);
      check_output($sformatf("cnt%0d_done", k), done, k == 40);
    end
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    check_output("done_restart_number", number, 0);
    check_output("done_restart_state", state_o, S_RUN);

    // Wrap downwards through zero.
    apply_stimulus(0, 0, 1, 0, 0, 0, 1);
    apply_stimulus(0, 0, 0, 1, 2, 0, 1);
    apply_stimulus(1, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 16; k++) begin
      idle_cycle(0, 1);
      check_output($sformatf("wrap%0d_number", k), number, seq_b[k / 4]);
      check_output($sformatf("wrap%0d_tick", k), tick_o, k % 4 == 0);
      check_output($sformatf("wrap%0d_state", k), state_o, S_RUN);
      check_output($sformatf("wrap%0d_done", k), done, 0);
    end

    // Pause with pre==1 at number 3, then resume: step after DIV-1 cycles.
    apply_stimulus(0, 0, 1, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 13; k++) idle_cycle(1, 0);
    apply_stimulus(0, 1, 0, 0, 0, 1, 0);
    check_output("pause_number", number, 3);
    check_output("pause_state", state_o, S_PAUSE);
    for (int k = 0; k < 20; k++) begin
      idle_cycle(1, 0);
      check_output($sformatf("hold%0d_number", k), number, 3);
      check_output($sformatf("hold%0d_state", k), state_o, S_PAUSE);
    end
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    check_output("resume_state", state_o, S_RUN);
    for (int j = 1; j <= 3; j++) begin
      idle_cycle(1, 0);
      check_output($sformatf("resume%0d_number", j), number, (j == 3) ? 4 : 3);
      check_output($sformatf("resume%0d_tick", j), tick_o, j == 3);
    end

    // Asynchronous reset between edges while running at 7.
    apply_stimulus(0, 0, 1, 0, 0, 1, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 28; k++) idle_cycle(1, 0);
    check_output("prereset_number", number, 7);
    #3 rst_n = 0;
    model_reset();
    #1;
    check_output("async_number", number, 0);
    check_output("async_state", state_o, S_IDLE);
    check_output("async_tick", tick_o, 0);
    check_output("async_done", done, 0);
    #2 rst_n = 1;
    for (int k = 0; k < 10; k++) begin
      idle_cycle(1, 0);
      check_output($sformatf("postrst%0d_number", k), number, 0);
      check_output($sformatf("postrst%0d_state", k), state_o, S_IDLE);
    end
    apply_stimulus(1, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 4; k++) begin
      idle_cycle(1, 0);
      check_output($sformatf("restart%0d_number", k), number, (k == 4) ? 1 : 0);
    end

    // Random traffic against the reference model.
    #3 rst_n = 0;
    model_reset();
    #2 rst_n = 1;
    begin
      bit r_up = 1;
      for (int c = 0; c < 2000; c++) begin
        if ($urandom_range(15) == 0) r_up = ~r_up;
        apply_stimulus($urandom_range(7) == 0, $urandom_range(15) == 0,
                       $urandom_range(63) == 0, $urandom_range(31) == 0,
                       int'($urandom_range(63)), r_up, $urandom_range(3) != 0);
        check_model($sformatf("rnd%0d", c));
      end
    end

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
